// File: rtl/dac_i2c_target.sv
// rtl/dac_i2c_target.sv - I2C target holding two 16-bit DAC channel registers
// Register read-back is built only when DAC_I2C_TARGET_READ_EN is defined.
module dac_i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'b110_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic [15:0] ch0_value,
  output logic [15:0] ch1_value,
  output logic        update,
  output logic        update_ch,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, DATA_HI, HI_ACK, DATA_LO, LO_ACK, IGNORE
`ifdef DAC_I2C_TARGET_READ_EN
    , TX_HI, TX_HI_ACK, TX_LO, TX_LO_ACK
`endif
  } state_t;

  state_t      state, state_nxt;
  logic        sda_nxt;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_s, sda_s, scl_prev, sda_prev;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [3:0]  bit_cnt;
  logic [7:0]  rx_sh;
  logic [7:0]  shadow;
  logic        wr_reg;
  logic        byte_done, addr_match, reg_ok, wr_cmd;
  logic [15:0] lo_word;
  logic        bit_clr, shadow_ld, commit, wr_reg_ld, busy_set, busy_clr;

`ifdef DAC_I2C_TARGET_READ_EN
  logic        rd_reg, ack_rd, ack_rd_nxt, mack;
  logic [7:0]  tx_sh;
  logic [15:0] tx_word;
  logic        rd_cmd, rd_reg_ld, tx_ld, tx_lo_sel, tx_shift, mack_ld;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      scl_prev <= scl_s;
      sda_prev <= sda_s;
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

  // bit_cnt reaches 8 on the eighth rise; the following fall opens the ACK slot
  assign byte_done  = scl_fall && (bit_cnt == 4'd8);
  assign addr_match = (rx_sh[7:1] == TARGET_ADDR);
  assign reg_ok     = (rx_sh[7:4] == 4'd0);
  assign wr_cmd     = reg_ok && (rx_sh[2:1] == 2'b00);
  assign lo_word    = {shadow, rx_sh[6:0], sda_s};

`ifdef DAC_I2C_TARGET_READ_EN
  assign rd_cmd  = reg_ok && (rx_sh[2:1] == 2'b11);
  assign tx_word = rd_reg ? ch1_value : ch0_value;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sda_o <= 1'b1;
    end else begin
      state <= state_nxt;
      sda_o <= sda_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sda_nxt   = sda_o;
    bit_clr   = 1'b0;
    shadow_ld = 1'b0;
    commit    = 1'b0;
    wr_reg_ld = 1'b0;
    busy_set  = 1'b0;
    busy_clr  = 1'b0;
`ifdef DAC_I2C_TARGET_READ_EN
    ack_rd_nxt = ack_rd;
    rd_reg_ld  = 1'b0;
    tx_ld      = 1'b0;
    tx_lo_sel  = 1'b0;
    tx_shift   = 1'b0;
    mack_ld    = 1'b0;
`endif
    if (start_det) begin
      state_nxt = ADDR;
      sda_nxt   = 1'b1;
      bit_clr   = 1'b1;
      busy_clr  = 1'b1;
    end else if (stop_det) begin
      state_nxt = IDLE;
      sda_nxt   = 1'b1;
      busy_clr  = 1'b1;
    end else begin
      case (state)
        IDLE: ;
        ADDR: if (byte_done) begin
          busy_set = addr_match;
          if (addr_match && !rx_sh[0]) begin
            sda_nxt   = 1'b0;
            state_nxt = ADDR_ACK;
`ifdef DAC_I2C_TARGET_READ_EN
            ack_rd_nxt = 1'b0;
          end else if (addr_match && rx_sh[0]) begin
            sda_nxt    = 1'b0;
            state_nxt  = ADDR_ACK;
            ack_rd_nxt = 1'b1;
`endif
          end else begin
            state_nxt = IGNORE;
          end
        end
        ADDR_ACK: if (scl_fall) begin
          sda_nxt   = 1'b1;
          bit_clr   = 1'b1;
          state_nxt = CMD;
`ifdef DAC_I2C_TARGET_READ_EN
          if (ack_rd) begin
            state_nxt = TX_HI;
            tx_ld     = 1'b1;
            sda_nxt   = tx_word[15];
          end
`endif
        end
        CMD: if (byte_done) begin
          if (wr_cmd) begin
            sda_nxt   = 1'b0;
            wr_reg_ld = 1'b1;
            state_nxt = CMD_ACK;
`ifdef DAC_I2C_TARGET_READ_EN
            ack_rd_nxt = 1'b0;
          end else if (rd_cmd) begin
            sda_nxt    = 1'b0;
            rd_reg_ld  = 1'b1;
            ack_rd_nxt = 1'b1;
            state_nxt  = CMD_ACK;
`endif
          end else begin
            state_nxt = IGNORE;
          end
        end
        CMD_ACK: if (scl_fall) begin
          sda_nxt   = 1'b1;
          bit_clr   = 1'b1;
          state_nxt = DATA_HI;
`ifdef DAC_I2C_TARGET_READ_EN
          // a read command only arms the index; data follows a repeated START
          if (ack_rd) state_nxt = IGNORE;
`endif
        end
        DATA_HI: if (byte_done) begin
          sda_nxt   = 1'b0;
          shadow_ld = 1'b1;
          state_nxt = HI_ACK;
        end
        HI_ACK: if (scl_fall) begin
          sda_nxt   = 1'b1;
          bit_clr   = 1'b1;
          state_nxt = DATA_LO;
        end
        DATA_LO: begin
          commit = scl_rise && (bit_cnt == 4'd7);
          if (byte_done) begin
            sda_nxt   = 1'b0;
            state_nxt = LO_ACK;
          end
        end
        LO_ACK: if (scl_fall) begin
          sda_nxt   = 1'b1;
          bit_clr   = 1'b1;
          state_nxt = CMD;
        end
        IGNORE: sda_nxt = 1'b1;
`ifdef DAC_I2C_TARGET_READ_EN
        TX_HI, TX_LO: if (scl_fall) begin
          if (bit_cnt == 4'd8) begin
            sda_nxt   = 1'b1;
            state_nxt = (state == TX_HI) ? TX_HI_ACK : TX_LO_ACK;
          end else begin
            sda_nxt  = tx_sh[7];
            tx_shift = 1'b1;
          end
        end
        TX_HI_ACK, TX_LO_ACK: begin
          mack_ld = scl_rise;
          if (scl_fall) begin
            if (!mack) begin
              tx_ld     = 1'b1;
              bit_clr   = 1'b1;
              tx_lo_sel = (state == TX_HI_ACK);
              state_nxt = (state == TX_HI_ACK) ? TX_LO : TX_HI;
              sda_nxt   = (state == TX_HI_ACK) ? tx_word[7] : tx_word[15];
            end else begin
              sda_nxt   = 1'b1;
              state_nxt = IGNORE;
            end
          end
        end
`endif
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt   <= 4'd0;
      rx_sh     <= 8'd0;
      shadow    <= 8'd0;
      wr_reg    <= 1'b0;
      ch0_value <= 16'h0000;
      ch1_value <= 16'h0000;
      update    <= 1'b0;
      update_ch <= 1'b0;
      busy      <= 1'b0;
    end else begin
      update <= commit;
      if (commit) begin
        if (wr_reg) ch1_value <= lo_word;
        else        ch0_value <= lo_word;
        update_ch <= wr_reg;
      end
      if (scl_rise) rx_sh <= {rx_sh[6:0], sda_s};
      if (bit_clr)       bit_cnt <= 4'd0;
      else if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
      if (shadow_ld) shadow <= rx_sh;
      if (wr_reg_ld) wr_reg <= rx_sh[3];
      if (busy_clr)      busy <= 1'b0;
      else if (busy_set) busy <= 1'b1;
    end
  end

`ifdef DAC_I2C_TARGET_READ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_reg <= 1'b0;
      ack_rd <= 1'b0;
      mack   <= 1'b1;
      tx_sh  <= 8'd0;
    end else begin
      ack_rd <= ack_rd_nxt;
      // the read index survives a repeated START but not a STOP
      if (stop_det)       rd_reg <= 1'b0;
      else if (rd_reg_ld) rd_reg <= rx_sh[3];
      if (mack_ld) mack <= sda_s;
      if (tx_ld)
        tx_sh <= tx_lo_sel ? {tx_word[6:0], 1'b0} : {tx_word[14:8], 1'b0};
      else if (tx_shift)
        tx_sh <= {tx_sh[6:0], 1'b0};
    end
  end
`endif

endmodule

// File: tb/tb_dac_i2c_target.sv
// tb/tb_dac_i2c_target.sv - directed and randomized bench for dac_i2c_target
// Drives an I2C master on a wired-AND SDA and compares against a byte-level model.
module tb_dac_i2c_target;
  localparam int Q = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_o, update, update_ch, busy;
  logic [15:0] ch0_value, ch1_value;

  assign sda_line = sda_m & sda_o;

  dac_i2c_target dut (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_line), .sda_o(sda_o),
    .ch0_value(ch0_value), .ch1_value(ch1_value),
    .update(update), .update_ch(update_ch), .busy(busy)
  );

  always #5 clk = ~clk;

  int   upd_cnt = 0;
  int   low_cnt = 0;
  logic last_ch = 1'b0;
  time  last_upd_t = 0;
  always @(negedge clk) begin
    if (update) begin
      upd_cnt++;
      last_ch = update_ch;
      last_upd_t = $time;
    end
    if (!sda_o) low_cnt++;
  end

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] m_ch [2];
  int          exp_upd = 0;
  logic        exp_last_ch = 1'b0;
  time         lsb_t = 0;
  logic [7:0]  txb [16];
  logic        exp_ack [16];
  int          n_tx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_start();
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      sda_m = b[i]; #Q;
      scl = 1'b1;
      if (i == 0) lsb_t = $time;
      #(2*Q);
      scl = 1'b0; #Q;
    end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; ack = ~sda_o; #Q; scl = 1'b0; #Q;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      #Q; scl = 1'b1; #Q; b[i] = sda_line; #Q; scl = 1'b0; #Q;
    end
    sda_m = ~master_ack; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q; sda_m = 1'b1;
  endtask

  // Byte-level reference: address, then repeating {command, high, low} groups.
  task automatic model_txn();
    logic       alive;
    int         phase;
    logic       r;
    logic [7:0] hi;
    alive = (txb[0][7:1] == 7'h60) && (txb[0][0] == 1'b0);
    exp_ack[0] = alive;
    phase = 0; r = 1'b0; hi = 8'd0;
    for (int k = 1; k < n_tx; k++) begin
      exp_ack[k] = 1'b0;
      if (alive) begin
        if (phase == 0) begin
          if (txb[k][7:4] == 4'd0 && txb[k][2:1] == 2'b00) begin
            exp_ack[k] = 1'b1; r = txb[k][3]; phase = 1;
          end else begin
`ifdef DAC_I2C_TARGET_READ_EN
            exp_ack[k] = (txb[k][7:4] == 4'd0 && txb[k][2:1] == 2'b11);
`endif
            alive = 1'b0;
          end
        end else if (phase == 1) begin
          exp_ack[k] = 1'b1; hi = txb[k]; phase = 2;
        end else begin
          exp_ack[k] = 1'b1;
          m_ch[r] = {hi, txb[k]};
          exp_upd++;
          exp_last_ch = r;
          phase = 0;
        end
      end
    end
  endtask

  task automatic run_txn(input string tag, input int tail_bits);
    logic a;
    model_txn();
    bus_start();
    for (int k = 0; k < n_tx; k++) begin
      write_byte(txb[k], a);
      check($sformatf("%s_ack%0d", tag, k), a, exp_ack[k]);
      if (k == 0) check({tag, "_busy"}, busy, txb[0][7:1] == 7'h60);
    end
    if (tail_bits > 0) begin
      send_bits(8'($urandom), tail_bits);
      bus_start();
    end
    bus_stop();
    check({tag, "_ch0"}, ch0_value, m_ch[0]);
    check({tag, "_ch1"}, ch1_value, m_ch[1]);
    check({tag, "_updates"}, upd_cnt, exp_upd);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    logic       a;
    logic [7:0] rb;
    int         low0;
    m_ch[0] = 16'h0000;
    m_ch[1] = 16'h0000;

    #20;
    check("rst_sda", sda_o, 1);
    check("rst_ch0", ch0_value, 0);
    check("rst_ch1", ch1_value, 0);
    check("rst_update", update, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    #40;

    txb[0] = 8'hC0; txb[1] = 8'h08; txb[2] = 8'h0A; txb[3] = 8'hBC; n_tx = 4;
    run_txn("wr_ch1", 0);
    check("wr_ch1_latency", (last_upd_t > lsb_t) && (last_upd_t - lsb_t <= 40), 1);
    check("wr_ch1_upd_ch", last_ch, 1);

    low0 = low_cnt;
    txb[0] = 8'hC2; txb[1] = 8'h08; txb[2] = 8'h12; txb[3] = 8'h34; n_tx = 4;
    run_txn("bad_addr", 0);
    check("bad_addr_sda_low", low_cnt - low0, 0);

    txb[0] = 8'hC0; txb[1] = 8'h00; txb[2] = 8'h5A; n_tx = 3;
    run_txn("hi_only", 0);
    run_txn("lo_abort", 3);

    txb[0] = 8'hC0; txb[1] = 8'h00; txb[2] = 8'h12; txb[3] = 8'h34;
    txb[4] = 8'h08; txb[5] = 8'h56; txb[6] = 8'h78; n_tx = 7;
    run_txn("cont_wr", 0);
    check("cont_wr_last_ch", last_ch, 1);

    bus_start();
    write_byte(8'hC0, a); check("rst_mid_ack0", a, 1);
    write_byte(8'h00, a); check("rst_mid_ack1", a, 1);
    send_bits(8'h77, 8);
    check("rst_mid_drive", sda_o, 0);
    rst = 1'b0; #1;
    check("rst_mid_sda", sda_o, 1);
    #9;
    check("rst_mid_ch0", ch0_value, 0);
    check("rst_mid_ch1", ch1_value, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_update", update, 0);
    m_ch[0] = 16'h0000;
    m_ch[1] = 16'h0000;
    #20; rst = 1'b1; #40;
    txb[0] = 8'hC0; txb[1] = 8'h08; txb[2] = 8'hAB; txb[3] = 8'hCD; n_tx = 4;
    run_txn("post_rst", 0);

`ifdef DAC_I2C_TARGET_READ_EN
    txb[0] = 8'hC0; txb[1] = 8'h00; txb[2] = 8'hBE; txb[3] = 8'hEF; n_tx = 4;
    run_txn("rd_setup", 0);
    bus_start();
    write_byte(8'hC0, a); check("rd_ack_addr", a, 1);
    write_byte(8'h06, a); check("rd_ack_cmd", a, 1);
    bus_start();
    write_byte(8'hC1, a); check("rd_ack_raddr", a, 1);
    read_byte(1'b1, rb); check("rd_byte_hi", rb, 8'hBE);
    read_byte(1'b0, rb); check("rd_byte_lo", rb, 8'hEF);
    bus_stop();
    check("rd_busy", busy, 0);
    check("rd_ch0", ch0_value, 16'hBEEF);
`else
    bus_start();
    write_byte(8'hC0, a); check("rdcmd_ack_addr", a, 1);
    write_byte(8'h06, a); check("rdcmd_nack", a, 0);
    bus_stop();
    bus_start();
    write_byte(8'hC1, a); check("raddr_nack", a, 0);
    bus_stop();
    check("rdcmd_ch0", ch0_value, m_ch[0]);
    check("rdcmd_updates", upd_cnt, exp_upd);
`endif

    for (int t = 0; t < 12; t++) begin
      int nw;
      int tail;
      txb[0] = 8'hC0;
      if ($urandom_range(4) == 0) txb[0] = {7'($urandom_range(127)), 1'b0};
`ifndef DAC_I2C_TARGET_READ_EN
      if ($urandom_range(7) == 0) txb[0][0] = 1'b1;
`endif
      nw = $urandom_range(1, 2);
      n_tx = 1;
      for (int w = 0; w < nw; w++) begin
        txb[n_tx] = {4'd0, 1'($urandom_range(1)), 3'b000};
        if ($urandom_range(5) == 0) txb[n_tx] = 8'($urandom);
        txb[n_tx + 1] = 8'($urandom);
        txb[n_tx + 2] = 8'($urandom);
        n_tx += 3;
      end
      if ($urandom_range(3) == 0) n_tx -= $urandom_range(1, 2);
      tail = ($urandom_range(3) == 0) ? $urandom_range(1, 7) : 0;
      run_txn($sformatf("rnd%0d", t), tail);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dac_i2c_target.md
DAC_I2C_TARGET -- requirements
Module: dac_i2c_target

Interface
REQ-001 Parameter: TARGET_ADDR, default 7'b110_0000, 7-bit I2C address the block answers to.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 scl_i  input  1  raw I2C SCL line level, asynchronous to clk.
REQ-005 sda_i  input  1  raw I2C SDA line level, asynchronous to clk.
REQ-006 sda_o  output  1  open-drain control: 0 = pull SDA low, 1 = release.
REQ-007 ch0_value  output  16  last committed value of register 0.
REQ-008 ch1_value  output  16  last committed value of register 1.
REQ-009 update  output  1  one-cycle pulse when a register is committed.
REQ-010 update_ch  output  1  register index of the latest commit; valid while update=1.
REQ-011 busy  output  1  high from an address match until the next STOP or START.

Function
REQ-012 scl_i and sda_i SHALL pass through 2-FF synchronizers; all edge detection SHALL use synchronized values; clk SHALL be at least 20x the SCL frequency.
REQ-013 START (SDA falls while SCL high) SHALL abort any state, discard any partial byte, and enter ADDR; this includes repeated START.
REQ-014 STOP (SDA rises while SCL high) SHALL release sda_o and enter IDLE from any state.
REQ-015 Data bits SHALL be sampled on the SCL rising edge, MSB first; sda_o SHALL change only on an SCL falling edge; no clock stretching.
REQ-016 States: IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, DATA_HI, HI_ACK, DATA_LO, LO_ACK, TX_HI, TX_HI_ACK, TX_LO, TX_LO_ACK, IGNORE.
REQ-017 ADDR: if the 7 address bits equal TARGET_ADDR and R/W=0, ACK and go to CMD; if the address does not match, do not ACK and go to IGNORE.
REQ-018 ACK is sda_o=0 from the SCL fall after bit 8 to the SCL fall after bit 9; for a NACK, sda_o stays 1.
REQ-019 Command byte layout is {reg[4:0], cmd[1:0], 1'b0}. reg 0 or 1 with cmd 2'b00 SHALL ACK and go to DATA_HI; any other reg or cmd SHALL NACK and go to IGNORE, except as given in REQ-029.
REQ-020 DATA_HI: ACK and hold the byte in a shadow register; ch outputs do not change.
REQ-021 DATA_LO: ACK, then commit {shadow, byte} atomically to the addressed chX_value, with update=1 and update_ch=reg for exactly one clk cycle.
REQ-022 Commit SHALL occur within 4 clk cycles of the external SCL rise that samples LSB bit 0.
REQ-023 After LO_ACK, the next byte SHALL be treated as a new command byte (continuous write within one transaction).
REQ-024 A STOP or START before the DATA_LO sample completes SHALL leave both chX_value unchanged and produce no update pulse.
REQ-025 IGNORE: sda_o=1 and all bits are ignored until START or STOP.

Reset
REQ-026 While rst=0: sda_o=1 immediately (asynchronously), ch0_value=16'h0000, ch1_value=16'h0000, update=0, update_ch=0, busy=0, state=IDLE, and synchronizers preset to 1.
REQ-027 Reset asserted mid-transaction SHALL discard the transaction; after release, the block SHALL wait in IDLE for a fresh START.

Configuration
REQ-028 Macro DAC_I2C_TARGET_READ_EN SHALL control register read-back support.
REQ-029 With DAC_I2C_TARGET_READ_EN defined:
- Command byte: cmd 2'b11 with reg 0/1 SHALL ACK, latch the register index, and await a repeated START.
- Address byte with R/W=1 SHALL ACK and go to TX_HI.
- TX_HI / TX_LO SHALL shift out the MSB, then the LSB, of the latched register, driving sda_o on SCL falls.
- A master ACK after TX_LO SHALL restart at TX_HI.
- A master NACK SHALL go to IGNORE.
- An address with R/W=1 and no prior read command SHALL read register 0.
REQ-030 Without DAC_I2C_TARGET_READ_EN: no TX states are synthesized; cmd 2'b11 is NACKed, and an address byte with R/W=1 is NACKed, entering IGNORE.

Verification
REQ-031 Write transaction START, C0, 08, 0A, BC, STOP -> 4 ACKs, ch1_value=0x0ABC, one update pulse with update_ch=1, ch0_value unchanged.
REQ-032 Address byte C2 (address 0x61), then 08, 12, 34 -> address NACKed, sda_o=1 throughout, busy=0, no update.
REQ-033 START, C0, 00, 5A, STOP -> 3 ACKs, no update, ch0_value stays 0x0000; repeat with a START after 3 bits of LO -> same result.
REQ-034 Write to reg 0 with data 12, 34, then continue in the same transaction with 08, 56, 78 -> two update pulses; ch0=0x1234, ch1=0x5678.
REQ-035 rst pulled low during HI_ACK -> sda_o=1 within the same cycle, outputs zeroed; the next full write succeeds.
REQ-036 READ_EN defined: ch0=0xBEEF; START, C0, 06, repeated START, C1, read two bytes, master NACK, STOP -> target returns BE, EF. READ_EN undefined: byte 06 is NACKed.
